rom_boot_arbiter: RTL

// Sequences SoC bring-up and owns the instruction ROM ports. After reset it holds the

---
 rtl/rom_boot_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rom_boot_arbiter.sv
// -----------------------------------------------------------------------------
// rom_boot_arbiter
//
// Sequences SoC bring-up and owns the instruction ROM ports.
//   LOAD    : the core is held in reset while a loader streams words into ROM
//             (write path is a straight pass-through of the loader bus).
//   RELEASE : the core stays in reset for RELEASE_CYC cycles after the last word.
//   RUN     : the core is out of reset. The single ROM read port is shared
//             between instruction fetch (default owner) and a debug reader.
//             A pending debug read is forced through after DBG_MAX_WAIT cycles.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   ld_valid/ld_ready/ld_addr/
//   ld_data/ld_last              loader stream (accepted on valid & ready)
//   core_rst_n                   registered active-low reset to the core
//   if_addr/if_inst/stall        core fetch port (if_inst combinational)
//   dbg_req/dbg_addr/
//   dbg_rvalid/dbg_rdata         debug read port (rdata/rvalid registered)
//   rom_we/rom_waddr/rom_wdata   ROM write port
//   rom_raddr/rom_rdata          ROM combinational read port
// -----------------------------------------------------------------------------
module rom_boot_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int RELEASE_CYC  = 4,
  parameter int DBG_MAX_WAIT = 8,
  parameter int BOOT_BYPASS  = 0
) (
  input  logic              clk,
  input  logic              rst,
  // loader
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  // core
  output logic              core_rst_n,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              stall,
  // debug
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  // ROM
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [DATA_W-1:0] rom_wdata,
  output logic [ADDR_W-1:0] rom_raddr,
  input  logic [DATA_W-1:0] rom_rdata
);

  localparam int REL_W  = (RELEASE_CYC  > 1) ? $clog2(RELEASE_CYC  + 1) : 1;
  localparam int WAIT_W = (DBG_MAX_WAIT > 1) ? $clog2(DBG_MAX_WAIT + 1) : 1;

  localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(RELEASE_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DBG_MAX_WAIT - 1);

  // RISC-V "addi x0,x0,0" fed to the core whenever fetch is not serviced
  localparam logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h0000_0013);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  localparam state_t   RESET_STATE = (BOOT_BYPASS != 0) ? ST_RUN : ST_LOAD;
  localparam logic     RESET_CORE  = (BOOT_BYPASS != 0);

  state_t              state_reg;
  logic [REL_W-1:0]    rel_cnt_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic                dbg_grant_reg;   // debug owns the read port this cycle
  logic                dbg_served_reg;  // current request already granted

  logic                ld_accept;
  logic                fetch_grant;
  logic                dbg_pending;

  // ---------------------------------------------------------------------------
  // Combinational port steering
  // ---------------------------------------------------------------------------
  // ld_ready is only ever high in LOAD, so gating by it confines writes there.
  assign ld_accept = ld_valid & ld_ready;

  assign rom_we    = ld_accept;
  assign rom_waddr = ld_addr;
  assign rom_wdata = ld_data;

  assign fetch_grant = (state_reg == ST_RUN) && !dbg_grant_reg;
  assign stall       = !fetch_grant;
  assign rom_raddr   = dbg_grant_reg ? dbg_addr : if_addr;
  assign if_inst     = fetch_grant ? rom_rdata : NOP_INST;

  // A request is live until it has been granted once; the served flag holds it
  // off while dbg_req is still high during and right after the data return.
  assign dbg_pending = (state_reg == ST_RUN) && dbg_req &&
                       !dbg_grant_reg && !dbg_served_reg;

  // ---------------------------------------------------------------------------
  // Bring-up FSM, debug arbitration and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= RESET_STATE;
      rel_cnt_reg    <= '0;
      wait_cnt_reg   <= '0;
      dbg_grant_reg  <= 1'b0;
      dbg_served_reg <= 1'b0;
      ld_ready       <= 1'b0;
      core_rst_n     <= RESET_CORE;
      dbg_rvalid     <= 1'b0;
      dbg_rdata      <= '0;
    end else begin
      // defaults: one-cycle pulses fall back
      dbg_rvalid <= 1'b0;

      case (state_reg)
        ST_LOAD: begin
          core_rst_n <= 1'b0;
          if (ld_accept && ld_last) begin
            state_reg   <= ST_RELEASE;
            ld_ready    <= 1'b0;
            rel_cnt_reg <= '0;
          end else begin
            ld_ready <= 1'b1;
          end
        end

        ST_RELEASE: begin
          ld_ready <= 1'b0;
          if (rel_cnt_reg == REL_LAST) begin
            state_reg  <= ST_RUN;
            core_rst_n <= 1'b1;
          end else begin
            rel_cnt_reg <= rel_cnt_reg + REL_W'(1);
          end
        end

        ST_RUN: begin
          ld_ready   <= 1'b0;
          core_rst_n <= 1'b1;

          // grant cycle: capture ROM data, present it next cycle
          if (dbg_grant_reg) begin
            dbg_grant_reg <= 1'b0;
            dbg_rdata     <= rom_rdata;
            dbg_rvalid    <= 1'b1;
          end

          if (dbg_pending) begin
            // fetch always requests in RUN, so debug only wins by timeout
            if (wait_cnt_reg == WAIT_LAST) begin
              dbg_grant_reg  <= 1'b1;
              dbg_served_reg <= 1'b1;
              wait_cnt_reg   <= '0;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
            end
          end else if (!dbg_req) begin
            // request dropped: next assertion starts a fresh wait
            wait_cnt_reg   <= '0;
            dbg_served_reg <= 1'b0;
          end
        end

        default: begin
          state_reg <= RESET_STATE;
        end
      endcase
    end
  end

endmodule
